// File: rtl/memory_responder_pkg.sv
// ---------------------------------------------------------------------------
// memory_responder_pkg
// Shared definitions for the memory responder slice:
//   - DEPTH / ADDR_BITS defaults for the word array
//   - FSM state constants (IDLE, WAIT, ACCESS, RESP)
//   - request op encoding (OP_RD, OP_WR, OP_ERR)
//   - addr_in_range(): true when no address bit at or above addr_bits is set
// ---------------------------------------------------------------------------
package memory_responder_pkg;

  localparam int DEFAULT_DEPTH     = 512;
  localparam int DEFAULT_ADDR_BITS = 9;

  // FSM state encoding, kept as plain constants so the state register is a
  // simple 2-bit vector in every tool.
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  // OP_ERR marks a request that arrived with read and write both high.
  typedef enum logic [1:0] {
    OP_RD  = 2'd0,
    OP_WR  = 2'd1,
    OP_ERR = 2'd2
  } op_e;

  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int          addr_bits);
    return (addr >> addr_bits) == 32'd0;
  endfunction

endpackage

// File: rtl/memory_responder_if.sv
// ---------------------------------------------------------------------------
// memory_responder_if
// Datapath <-> memory responder bus.
//   mar_addr  : word address from the MAR
//   mdr_wdata : write data from the MDR
//   read      : read request strobe
//   write     : write request strobe
//   data_in   : read data back to the MD mux
//   mem_ready : one-cycle completion pulse
//   busy      : responder is processing a request
//   err       : one-cycle error pulse, coincident with mem_ready
// master = datapath side, slave = responder side.
// ---------------------------------------------------------------------------
interface memory_responder_if;

  logic [31:0] mar_addr;
  logic [31:0] mdr_wdata;
  logic        read;
  logic        write;
  logic [31:0] data_in;
  logic        mem_ready;
  logic        busy;
  logic        err;

  modport master (
    output mar_addr, mdr_wdata, read, write,
    input  data_in, mem_ready, busy, err
  );

  modport slave (
    input  mar_addr, mdr_wdata, read, write,
    output data_in, mem_ready, busy, err
  );

endinterface

// File: rtl/memory_responder_ram_array.sv
// ---------------------------------------------------------------------------
// ram_array
// Synchronous single-port word RAM: one read or one write per enabled cycle.
//   clk   : clock
//   en    : access enable
//   we    : 1 = write wdata to addr, 0 = read addr into rdata
//   addr  : word address
//   wdata : write data
//   rdata : registered read data, holds between reads
// ---------------------------------------------------------------------------
module ram_array
  import memory_responder_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: the array has no reset, so it maps onto block RAM and keeps its
  // contents across clr; nothing here may be cleared.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/memory_responder.sv
// ---------------------------------------------------------------------------
// memory_responder
// Wait-stated memory slave for a simple datapath. A request seen in IDLE is
// latched, delayed by WAIT_CYCLES wait states, performs one array access and
// reports completion with a one-cycle mem_ready (plus err on a bad request).
//   clk : clock, rising edge
//   clr : asynchronous active-high reset
//   bus : memory_responder_if.slave (mar_addr, mdr_wdata, read, write in;
//         data_in, mem_ready, busy, err out)
// Requests with read and write both high, or with address bits at or above
// ADDR_BITS set, complete with err and never touch the array.
// ---------------------------------------------------------------------------
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int ADDR_BITS   = DEFAULT_ADDR_BITS,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               clr,
  memory_responder_if.slave  bus
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]           state;
  logic [3:0]           cnt;
  op_e                  op;
  op_e                  req_op;
  logic [ADDR_BITS-1:0] addr_q;
  logic [31:0]          wdata_q;
  logic                 oor_q;
  logic [31:0]          data_q;
  logic [31:0]          ram_rdata;
  logic                 ram_en;
  logic [31:0]          read_data;
  logic                 rd_resp;

  // NOTE: every variable written in always_comb is given a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    req_op = OP_ERR;
    if (bus.read && !bus.write) begin
      req_op = OP_RD;
    end else if (bus.write && !bus.read) begin
      req_op = OP_WR;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      op      <= OP_RD;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      oor_q   <= 1'b0;
      data_q  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          // Strobes are only looked at here; activity while busy is dropped.
          if (bus.read || bus.write) begin
            op      <= req_op;
            addr_q  <= bus.mar_addr[ADDR_BITS-1:0];
            wdata_q <= bus.mdr_wdata;
            oor_q   <= !addr_in_range(bus.mar_addr, ADDR_BITS);
            cnt     <= WAIT_INIT;
            state   <= (WAIT_CYCLES == 0) ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          // Leave on the edge where the counter reaches zero.
          if (cnt == 4'd1) begin
            state <= ACCESS;
          end
        end
        ACCESS: begin
          state <= RESP;
        end
        RESP: begin
          if (op == OP_RD) begin
            data_q <= read_data;
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Only good, in-range requests reach the array.
  assign ram_en = (state == ACCESS) && (op != OP_ERR) && !oor_q;

  ram_array #(
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (op == OP_WR),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // The RAM output register already holds the fresh word during RESP, so it
  // is forwarded for that cycle and captured into data_q for all later ones.
  // Both sources are registers; out-of-range reads return zero.
  assign read_data     = oor_q ? 32'd0 : ram_rdata;
  assign rd_resp       = (state == RESP) && (op == OP_RD);
  assign bus.data_in   = rd_resp ? read_data : data_q;
  assign bus.mem_ready = (state == RESP);
  assign bus.err       = (state == RESP) && ((op == OP_ERR) || oor_q);
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_memory_responder.sv
// ---------------------------------------------------------------------------
// tb_memory_responder
// Two responders share the clock: dut0 with no wait states, dut2 with two.
// A reference model (word map per responder plus last returned read data)
// predicts latency, err and data_in for every transaction.
// ---------------------------------------------------------------------------
module tb_memory_responder;

  localparam int DEPTH = 512;

  logic clk = 1'b0;
  logic clr0;
  logic clr2;

  always #5 clk = ~clk;

  memory_responder_if bus0 ();
  memory_responder_if bus2 ();

  memory_responder #(.DEPTH(DEPTH), .ADDR_BITS(9), .WAIT_CYCLES(0)) dut0 (
    .clk (clk),
    .clr (clr0),
    .bus (bus0)
  );

  memory_responder #(.DEPTH(DEPTH), .ADDR_BITS(9), .WAIT_CYCLES(2)) dut2 (
    .clk (clk),
    .clr (clr2),
    .bus (bus2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: sel 0 -> dut0, sel 1 -> dut2.
  logic [31:0] model [longint];
  logic [31:0] last_d [2];
  int          pool0 [$];
  int          pool1 [$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint key(input int sel, input logic [31:0] a);
    return longint'(sel) * 1024 + longint'(a);
  endfunction

  function automatic int waits(input int sel);
    return (sel == 0) ? 0 : 2;
  endfunction

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      bus0.read = rd; bus0.write = wr; bus0.mar_addr = a; bus0.mdr_wdata = d;
    end else begin
      bus2.read = rd; bus2.write = wr; bus2.mar_addr = a; bus2.mdr_wdata = d;
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? bus0.mem_ready : bus2.mem_ready;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 0) ? bus0.busy : bus2.busy;
  endfunction
  function automatic logic get_err(input int sel);
    return (sel == 0) ? bus0.err : bus2.err;
  endfunction
  function automatic logic [31:0] get_data(input int sel);
    return (sel == 0) ? bus0.data_in : bus2.data_in;
  endfunction

  // One request: strobes are presented for exactly one sampling edge, then
  // the address/data lines are scrambled while the responder is busy.
  task automatic xact(input int sel, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] d,
                      input string tag);
    int   n;
    logic got;
    logic oor;
    logic exp_e;

    oor   = (a >= 32'(DEPTH));
    exp_e = (rd && wr) || oor;
    if (rd && !wr) begin
      last_d[sel] = oor ? 32'd0 : model[key(sel, a)];
    end else if (wr && !rd && !oor) begin
      model[key(sel, a)] = d;
    end

    @(negedge clk);
    drive(sel, rd, wr, a, d);
    @(posedge clk);
    #1 drive(sel, 1'b0, 1'b0, $urandom, $urandom);

    n   = 1;
    got = 1'b0;
    while (!got && n <= 40) begin
      @(negedge clk);
      if (n == 1) check({tag, " busy"}, 32'(get_busy(sel)), 32'd1);
      if (get_ready(sel)) got = 1'b1;
      else n++;
    end
    check({tag, " ready seen"}, 32'(got), 32'd1);
    check({tag, " latency"}, n, waits(sel) + 2);
    check({tag, " err"}, 32'(get_err(sel)), 32'(exp_e));
    check({tag, " data_in"}, get_data(sel), last_d[sel]);
    @(negedge clk);
    check({tag, " ready one cycle"}, 32'(get_ready(sel)), 32'd0);
    check({tag, " data_in hold"}, get_data(sel), last_d[sel]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int first;
    int second;
    int r;
    int sel;
    logic [31:0] a;
    logic [31:0] d;

    clr0 = 1'b1;
    clr2 = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    last_d[0] = 32'd0;
    last_d[1] = 32'd0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset%0d data_in", s), get_data(s), 32'd0);
      check($sformatf("reset%0d mem_ready", s), 32'(get_ready(s)), 32'd0);
      check($sformatf("reset%0d busy", s), 32'(get_busy(s)), 32'd0);
      check($sformatf("reset%0d err", s), 32'(get_err(s)), 32'd0);
    end
    clr0 = 1'b0;
    clr2 = 1'b0;

    // Write then read back with two wait states.
    xact(1, 1'b0, 1'b1, 32'h05, 32'hDEADBEEF, "wr 0x05");
    xact(1, 1'b1, 1'b0, 32'h05, 32'h0, "rd 0x05");

    // Zero wait states on the last word.
    xact(0, 1'b0, 1'b1, 32'h1FF, 32'h12345678, "w0 wr 0x1FF");
    xact(0, 1'b1, 1'b0, 32'h1FF, 32'h0, "w0 rd 0x1FF");

    // Read and write together: error, array and data_in untouched.
    xact(1, 1'b0, 1'b1, 32'h10, 32'hAAAA0000, "wr 0x10");
    xact(1, 1'b1, 1'b1, 32'h10, 32'h5555FFFF, "both 0x10");
    xact(1, 1'b1, 1'b0, 32'h10, 32'h0, "rd 0x10");

    // Out-of-range addresses: no wrap onto 0x000.
    xact(1, 1'b0, 1'b1, 32'h000, 32'h13579BDF, "wr 0x000");
    xact(1, 1'b1, 1'b0, 32'h200, 32'h0, "rd 0x200");
    xact(1, 1'b1, 1'b0, 32'h05, 32'h0, "rd 0x05 again");
    xact(1, 1'b1, 1'b0, 32'h8000_0005, 32'h0, "rd hi bit");
    xact(1, 1'b0, 1'b1, 32'h200, 32'hFFFFFFFF, "wr 0x200");
    xact(1, 1'b1, 1'b0, 32'h000, 32'h0, "rd 0x000");

    // clr during WAIT aborts a write.
    xact(1, 1'b0, 1'b1, 32'h07, 32'h00000077, "wr 0x07");
    @(negedge clk);
    drive(1, 1'b0, 1'b1, 32'h07, 32'h1);
    @(posedge clk);
    #1 drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("abort busy in wait", 32'(bus2.busy), 32'd1);
    clr2 = 1'b1;
    #1;
    check("abort data_in", bus2.data_in, 32'd0);
    check("abort mem_ready", 32'(bus2.mem_ready), 32'd0);
    check("abort busy", 32'(bus2.busy), 32'd0);
    check("abort err", 32'(bus2.err), 32'd0);
    last_d[1] = 32'd0;
    @(negedge clk);
    clr2 = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus2.mem_ready) pulses++;
    end
    check("abort no ready", pulses, 0);
    xact(1, 1'b1, 1'b0, 32'h07, 32'h0, "rd 0x07 after abort");

    // Strobe activity while busy is ignored; a read held across RESP is
    // accepted again in the following IDLE cycle.
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'h05, 32'h0);
    @(posedge clk);
    pulses = 0;
    first  = 0;
    second = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus2.mem_ready) begin
        pulses++;
        check($sformatf("b2b data_in pulse %0d", pulses), bus2.data_in,
              model[key(1, 32'h05)]);
        if (pulses == 1) begin
          first = n;
        end else if (pulses == 2) begin
          second = n;
          bus2.read = 1'b0;
        end
      end else if (n == 1) begin
        bus2.read  = 1'b0;
        bus2.write = 1'b1;
      end else if (n == 2) begin
        bus2.read  = 1'b1;
        bus2.write = 1'b0;
      end
    end
    bus2.read  = 1'b0;
    bus2.write = 1'b0;
    last_d[1]  = model[key(1, 32'h05)];
    check("b2b pulse count", pulses, 2);
    check("b2b first pulse", first, 4);
    check("b2b second pulse", second, 9);

    // Randomized traffic on both responders.
    pool0.push_back(32'h1FF);
    pool1.push_back(32'h05);
    pool1.push_back(32'h000);
    for (int t = 0; t < 40; t++) begin
      sel = int'($urandom_range(0, 1));
      r   = int'($urandom_range(0, 9));
      d   = $urandom;
      if (r <= 3 || (r <= 6 && sel == 0 && pool0.size() == 0)) begin
        a = $urandom_range(0, 1) ? 32'($urandom_range(0, 63))
                                 : 32'($urandom_range(448, 511));
        if (sel == 0) pool0.push_back(int'(a)); else pool1.push_back(int'(a));
        xact(sel, 1'b0, 1'b1, a, d, $sformatf("rnd%0d wr", t));
      end else if (r <= 6) begin
        if (sel == 0) a = 32'(pool0[$urandom_range(0, pool0.size() - 1)]);
        else          a = 32'(pool1[$urandom_range(0, pool1.size() - 1)]);
        xact(sel, 1'b1, 1'b0, a, d, $sformatf("rnd%0d rd", t));
      end else if (r == 7) begin
        a = 32'(DEPTH) + 32'($urandom_range(0, 4000));
        xact(sel, 1'b1, 1'b0, a, d, $sformatf("rnd%0d rd oor", t));
      end else if (r == 8) begin
        a = 32'(DEPTH) + 32'($urandom_range(0, 4000));
        xact(sel, 1'b0, 1'b1, a, d, $sformatf("rnd%0d wr oor", t));
      end else begin
        a = 32'($urandom_range(0, 511));
        xact(sel, 1'b1, 1'b1, a, d, $sformatf("rnd%0d both", t));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
